basic_gates_df_unit: RTL and testbench

- Bit-parallel dataflow logic unit. Produces the AND, OR and NOT of two operand vectors.
- Each result is available both combinationally and as a one-cycle registered copy with a valid flag.
- Adds a registered operation-select result.
- Used as the basic logic-gate leaf under datapath control and in gate-level demo benches.

---
 rtl/basic_gates_df_unit.sv | 80 ++++++++
 tb/tb_basic_gates_df_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/basic_gates_df_unit.sv
// Bit-parallel AND/OR/NOT leaf: combinational results plus a one-cycle registered
// copy (with an op_sel-chosen result) qualified by out_valid.
module basic_gates_df_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_or,
    output logic [WIDTH-1:0] y_not,
    output logic [WIDTH-1:0] q_and,
    output logic [WIDTH-1:0] q_or,
    output logic [WIDTH-1:0] q_not,
    output logic [WIDTH-1:0] q_sel,
    output logic             out_valid
);

    function automatic logic [WIDTH-1:0] sel_result(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        case (op)
            2'b00:   sel_result = x & z;
            2'b01:   sel_result = x | z;
            2'b10:   sel_result = ~x;
            default: sel_result = ~z;
        endcase
    endfunction

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_not;
    logic [WIDTH-1:0] w_sel;

    assign w_and = a & b;
    assign w_or  = a | b;
    assign w_not = ~a;
    assign w_sel = sel_result(op_sel, a, b);

    assign y_and = w_and;
    assign y_or  = w_or;
    assign y_not = w_not;

    logic [WIDTH-1:0] r_and_p1;
    logic [WIDTH-1:0] r_or_p1;
    logic [WIDTH-1:0] r_not_p1;
    logic [WIDTH-1:0] r_sel_p1;
    logic             r_vld_p1;

    // p0 -> p1: capture on in_valid; reset clears data too, including q_not
    always_ff @(posedge clk) begin
        if (rst) begin
            r_and_p1 <= '0;
            r_or_p1  <= '0;
            r_not_p1 <= '0;
            r_sel_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_and_p1 <= w_and;
                r_or_p1  <= w_or;
                r_not_p1 <= w_not;
                r_sel_p1 <= w_sel;
            end
        end
    end

    assign q_and     = r_and_p1;
    assign q_or      = r_or_p1;
    assign q_not     = r_not_p1;
    assign q_sel     = r_sel_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_basic_gates_df_unit.sv
// Scoreboard bench for basic_gates_df_unit: WIDTH=1 truth table plus WIDTH=8
// directed and randomized traffic checked against a per-bit arithmetic model.
module tb_basic_gates_df_unit;

    typedef struct packed {
        logic [7:0] r_and;
        logic [7:0] r_or;
        logic [7:0] r_not;
        logic [7:0] r_sel;
    } res_t;

    logic       clk = 1'b0;
    logic       rst, in_valid;
    logic [7:0] a, b;
    logic [1:0] op_sel;
    logic [7:0] y_and, y_or, y_not, q_and, q_or, q_not, q_sel;
    logic       out_valid;

    logic       a1, b1, rst1, iv1;
    logic [1:0] op1;
    logic       y_and1, y_or1, y_not1, q_and1, q_or1, q_not1, q_sel1, ov1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    basic_gates_df_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .op_sel(op_sel),
        .y_and(y_and), .y_or(y_or), .y_not(y_not),
        .q_and(q_and), .q_or(q_or), .q_not(q_not), .q_sel(q_sel), .out_valid(out_valid)
    );

    basic_gates_df_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(iv1), .op_sel(op1),
        .y_and(y_and1), .y_or(y_or1), .y_not(y_not1),
        .q_and(q_and1), .q_or(q_or1), .q_not(q_not1), .q_sel(q_sel1), .out_valid(ov1)
    );

    // Reference: each bit treated as the integer 0/1 and combined arithmetically.
    function automatic res_t ref_model(input logic [7:0] x, input logic [7:0] z,
                                       input logic [1:0] op);
        res_t r;
        for (int i = 0; i < 8; i++) begin
            int xi, zi;
            xi = int'(x[i]);
            zi = int'(z[i]);
            r.r_and[i] = (xi * zi) != 0;
            r.r_or[i]  = (xi + zi - xi * zi) != 0;
            r.r_not[i] = (1 - xi) != 0;
        end
        case (op)
            2'd0:    r.r_sel = r.r_and;
            2'd1:    r.r_sel = r.r_or;
            2'd2:    r.r_sel = r.r_not;
            default: begin
                for (int i = 0; i < 8; i++) r.r_sel[i] = (1 - int'(z[i])) != 0;
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard producer: records what each sampling edge should yield.
    res_t q_exp[$];
    logic exp_vld = 1'b0;
    logic clear_pending = 1'b0;
    logic started = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            q_exp.delete();
            exp_vld = 1'b0;
            clear_pending = 1'b1;
            started = 1'b1;
        end else if (in_valid === 1'b1) begin
            q_exp.push_back(ref_model(a, b, op_sel));
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
    end

    // Scoreboard consumer / monitor.
    res_t held = '0;
    always @(negedge clk) begin
        if (started) begin
            res_t e, c;
            if (clear_pending) begin
                held = '0;
                clear_pending = 1'b0;
            end
            chk("out_valid", {7'd0, out_valid}, {7'd0, exp_vld});
            if (exp_vld) begin
                if (q_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: got out_valid expected queued result at %0t", $time);
                end else begin
                    held = q_exp.pop_front();
                end
            end
            chk("q_and", q_and, held.r_and);
            chk("q_or",  q_or,  held.r_or);
            chk("q_not", q_not, held.r_not);
            chk("q_sel", q_sel, held.r_sel);
            c = ref_model(a, b, op_sel);
            chk("y_and", y_and, c.r_and);
            chk("y_or",  y_or,  c.r_or);
            chk("y_not", y_not, c.r_not);
            e = held;
        end
    end

    task automatic drive(input logic r, input logic iv, input logic [7:0] x,
                         input logic [7:0] z, input logic [1:0] op);
        rst = r; in_valid = iv; a = x; b = z; op_sel = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] tt [4];
        logic [7:0] sel_exp [4];
        logic [7:0] ha, hb, hs;
        tt[0] = 3'b001; tt[1] = 3'b011; tt[2] = 3'b010; tt[3] = 3'b110;
        sel_exp[0] = 8'h05; sel_exp[1] = 8'hAF; sel_exp[2] = 8'h5A; sel_exp[3] = 8'hF0;
        rst1 = 1'b1; iv1 = 1'b0; op1 = 2'b00;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sel = '0;

        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = 2'(i);
            a1 = v[1]; b1 = v[0];
            #10;
            chk("tt_y_and", {7'd0, y_and1}, {7'd0, tt[i][2]});
            chk("tt_y_or",  {7'd0, y_or1},  {7'd0, tt[i][1]});
            chk("tt_y_not", {7'd0, y_not1}, {7'd0, tt[i][0]});
        end

        @(posedge clk); #1;
        drive(1, 0, 8'h00, 8'h00, 2'd0);
        drive(1, 0, 8'h00, 8'h00, 2'd0);
        @(negedge clk);
        chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
        chk("reset_q_not", q_not, 8'h00);

        drive(0, 1, 8'hF0, 8'h3C, 2'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid", {7'd0, out_valid}, 8'd1);
        chk("lat_q_and", q_and, 8'h30);
        chk("lat_q_or",  q_or,  8'hFC);
        chk("lat_q_not", q_not, 8'h0F);
        chk("lat_q_sel", q_sel, 8'h30);
        drive(0, 0, 8'h12, 8'h34, 2'd3);
        @(negedge clk);
        chk("lat_hold_valid", {7'd0, out_valid}, 8'd0);
        chk("lat_hold_q_and", q_and, 8'h30);
        chk("lat_hold_q_sel", q_sel, 8'h30);

        drive(0, 1, 8'hA5, 8'h0F, 2'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                rst = 1'b0; in_valid = 1'b1; a = 8'hA5; b = 8'h0F; op_sel = 2'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("opsel_valid", {7'd0, out_valid}, 8'd1);
            chk("opsel_q_sel", q_sel, sel_exp[i]);
            @(posedge clk); #1;
        end

        rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op_sel = 2'd1;
        #1;
        chk("rstpri_y_and", y_and, 8'hFF);
        chk("rstpri_y_or",  y_or,  8'hFF);
        chk("rstpri_y_not", y_not, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rstpri_valid", {7'd0, out_valid}, 8'd0);
        chk("rstpri_q_or", q_or, 8'h00);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) drive(0, 1, 8'($urandom), 8'($urandom), 2'($urandom));
        drive(1, 1, 8'($urandom), 8'($urandom), 2'($urandom));
        rst = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; op_sel = 2'd1;
        @(negedge clk);
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_q_sel", q_sel, 8'h00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_next_valid", {7'd0, out_valid}, 8'd1);
        chk("mid_rst_next_q_sel", q_sel, 8'h33);

        drive(0, 1, 8'h5C, 8'hC3, 2'd0);
        ha = 8'h5C & 8'hC3; hb = 8'h5C | 8'hC3; hs = ha;
        for (int i = 0; i < 5; i++) begin
            res_t c;
            rst = 1'b0; in_valid = 1'b0;
            a = 8'($urandom); b = 8'($urandom); op_sel = 2'($urandom);
            #1;
            c = ref_model(a, b, op_sel);
            chk("hold_y_and", y_and, c.r_and);
            chk("hold_q_and", q_and, ha);
            chk("hold_q_or",  q_or,  hb);
            chk("hold_q_sel", q_sel, hs);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                  8'($urandom), 8'($urandom), 2'($urandom));
        end
        drive(0, 0, 8'h00, 8'h00, 2'd0);
        @(negedge clk);
        @(negedge clk);
        if (q_exp.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
